// File: rtl/draw_dp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : draw_dp_arbiter
// Purpose  : Round-robin arbiter sharing one draw datapath among NUM_REQ
//            requesters; sequences ISSUE/SETTLE/WAIT/DONE per operation.
//            Optional WAIT timeout enabled by defining DP_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module draw_dp_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int INSTR_W        = 32,
    parameter int RESULT_W       = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [NUM_REQ*INSTR_W-1:0] i_req_instr,
    output logic [NUM_REQ-1:0]         o_req_grant,
    output logic [NUM_REQ-1:0]         o_req_done,
    output logic                       o_req_error,
    output logic [RESULT_W-1:0]        o_req_result,
    output logic                       o_dp_start,
    output logic [INSTR_W-1:0]         o_dp_instruction,
    input  logic                       i_dp_finished,
    input  logic [RESULT_W-1:0]        i_dp_result,
    output logic                       o_busy
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] c_ONE_HOT0 = NUM_REQ'(1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_SETTLE = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [c_IDX_W-1:0]   r_owner;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   r_done;
    logic [RESULT_W-1:0]  r_result;
    logic                 r_start;
    logic [INSTR_W-1:0]   r_instr;
    logic                 r_busy;

    logic [INSTR_W-1:0]   w_instr_arr [NUM_REQ];
    logic                 w_found;
    logic [c_IDX_W-1:0]   w_win_idx;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_instr_arr[g] = i_req_instr[g*INSTR_W +: INSTR_W];
    end

    // First requesting index at or after r_rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [c_IDX_W:0]   sum;
        logic [c_IDX_W-1:0] idx;
        w_found   = 1'b0;
        w_win_idx = '0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, r_rr_ptr} + (c_IDX_W+1)'(k);
            if (sum >= (c_IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (c_IDX_W+1)'(NUM_REQ);
            end
            idx = sum[c_IDX_W-1:0];
            if (!w_found && i_req_valid[idx]) begin
                w_found   = 1'b1;
                w_win_idx = idx;
            end
        end
    end

`ifdef DP_TIMEOUT_EN
    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_tmo_cnt;
    logic        r_error;
    assign o_req_error = r_error;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
    assign o_req_error  = 1'b0;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_grant  <= '0;
            r_done   <= '0;
            r_result <= '0;
            r_start  <= 1'b0;
            r_instr  <= '0;
            r_busy   <= 1'b0;
`ifdef DP_TIMEOUT_EN
            r_tmo_cnt <= '0;
            r_error   <= 1'b0;
`endif
        end else begin
            r_start <= 1'b0;
            r_done  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_win_idx;
                        r_grant <= c_ONE_HOT0 << w_win_idx;
                        r_instr <= w_instr_arr[w_win_idx];
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_SETTLE;
                end
                // A finished level left over from the previous op is ignored here.
                S_SETTLE: begin
`ifdef DP_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_dp_finished) begin
                        r_result <= i_dp_result;
                        r_done   <= r_grant;
`ifdef DP_TIMEOUT_EN
                        r_error  <= 1'b0;
`endif
                        r_state  <= S_DONE;
                    end
`ifdef DP_TIMEOUT_EN
                    else if (r_tmo_cnt == c_TMO_LAST) begin
                        r_result <= '0;
                        r_done   <= r_grant;
                        r_error  <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
`endif
                end
                S_DONE: begin
                    r_grant  <= '0;
                    r_busy   <= 1'b0;
                    r_rr_ptr <= (r_owner == c_LAST_IDX) ? '0 : r_owner + 1'b1;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req_grant      = r_grant;
    assign o_req_done       = r_done;
    assign o_req_result     = r_result;
    assign o_dp_start       = r_start;
    assign o_dp_instruction = r_instr;
    assign o_busy           = r_busy;

endmodule
`default_nettype wire
